// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO, sitting beside data RAM
// on the CPU data bus and claiming an 8-byte register window.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        hit,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic wr_txdata, wr_status;
  logic empty, full, pop, push_ok;
  logic unused_bits;

  // adr[1:0] and the upper store data never matter to this block.
  assign unused_bits = ^{adr[1:0], din[31:8]};

  assign hit       = (adr[31:3] == BASE_ADDR[31:3]);
  assign wr_txdata = we && hit && !adr[2];
  assign wr_status = we && hit && adr[2];

  assign empty   = (count_q == '0);
  assign full    = (count_q == COUNT_FULL);
  assign pop     = (state_q == S_IDLE) && !empty;
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push_ok = wr_txdata && (!full || pop);

  assign busy = (state_q != S_IDLE);
  assign tx   = tx_q;

  always_comb begin
    dout = '0;
    if (hit && adr[2]) begin
      dout = {28'b0, ovf_q, full, empty, busy};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (wr_txdata && !push_ok) begin
      ovf_d = 1'b1;
    end else if (wr_status) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // tx_q is loaded with the level of the state being entered, so the line
  // changes exactly on the edge that changes state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          bit_q  <= '0;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            state_q <= S_START;
            tx_q    <= 1'b0;
          end
        end
        S_START: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        S_DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        S_STOP: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
          tx_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule
